// File: rtl/aes_pkg.sv
// Shared constants, FSM encoding and byte-parity helper for the AES-128 round-key store.
// Parity helper is only used when RKEY_PARITY_EN is defined.
package aes_pkg;

    localparam int unsigned NR128 = 10;
    localparam int unsigned NSLOT = 11;
    localparam int unsigned RK_W  = 128;
    localparam int unsigned RK_PW = RK_W / 8;

    localparam logic [3:0] LAST_IDX = 4'(NR128);

    typedef enum logic [2:0] {
        StEmpty = 3'b001,
        StFill  = 3'b010,
        StReady = 3'b100
    } rk_state_e;

    // Even parity: the stored bit makes each byte plus its parity bit have even weight.
    function automatic logic [0:RK_PW-1] byte_parity(input logic [0:RK_W-1] d);
        logic [0:RK_PW-1] p;
        for (int b = 0; b < int'(RK_PW); b++) begin
            p[b] = ^d[8*b +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/rkey_ram.sv
// 11-entry round-key register array with one write port and one registered read port.
// With RKEY_PARITY_EN each entry carries 16 byte-parity bits, checked on the read register.
module rkey_ram
    import aes_pkg::*;
(
    input  logic            mclk,
    input  logic            arst_n,
    input  logic            we,
    input  logic [3:0]      wr_idx,
    input  logic [0:RK_W-1] wr_data,
    input  logic            re,
    input  logic [3:0]      rd_idx,
`ifdef RKEY_PARITY_EN
    output logic            par_err,
`endif
    output logic [0:RK_W-1] rd_data
);

`ifdef RKEY_PARITY_EN
    localparam int unsigned MW = RK_W + RK_PW;
`else
    localparam int unsigned MW = RK_W;
`endif

    logic [0:MW-1] mem_q [NSLOT];
    logic [0:MW-1] rd_q;
    logic [0:MW-1] wr_word;

`ifdef RKEY_PARITY_EN
    assign wr_word = {wr_data, byte_parity(wr_data)};
    assign par_err = byte_parity(rd_q[0:RK_W-1]) != rd_q[RK_W:MW-1];
`else
    assign wr_word = wr_data;
`endif

    // Key slots are deliberately not reset.
    always_ff @(posedge mclk) begin
        if (we) begin
            mem_q[wr_idx] <= wr_word;
        end
    end

    always_ff @(posedge mclk or negedge arst_n) begin
        if (!arst_n) begin
            rd_q <= '0;
        end else if (re) begin
            rd_q <= mem_q[rd_idx];
        end
    end

    assign rd_data = rd_q[0:RK_W-1];

endmodule

// File: rtl/rkey_store.sv
// AES-128 round-key schedule store: sequenced fill of 11 keys, then 1-cycle-latency reads.
// Optional per-byte parity on stored keys is enabled by defining RKEY_PARITY_EN.
module rkey_store
    import aes_pkg::*;
(
    input  logic            mclk,
    input  logic            arst_n,
    input  logic [0:RK_W-1] rk_in,
    input  logic [3:0]      rk_idx,
    input  logic            rk_le,
    input  logic            flush,
    input  logic            rd_req,
    input  logic [3:0]      rd_idx,
    output logic [0:RK_W-1] rd_key,
    output logic            rd_valid,
    output logic            keys_ready,
    output logic            wr_err,
    output logic            rd_err
);

    rk_state_e  state_q, state_d;
    logic [3:0] exp_q, exp_d;
    logic       wr_err_d, we;
    logic       rd_ok;
    logic       rd_valid_q, rd_err_q, keys_ready_q, wr_err_q;
    logic       par_bad;

    // Read is qualified by the pre-edge state, so it ignores same-cycle writes and flush.
    assign rd_ok = rd_req && (state_q == StReady) && (rd_idx <= LAST_IDX);

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        wr_err_d = 1'b0;
        we       = 1'b0;
        if (flush) begin
            state_d = StEmpty;
            exp_d   = '0;
        end else if (rk_le) begin
            unique case (state_q)
                StEmpty: begin
                    if (rk_idx == 4'd0) begin
                        we      = 1'b1;
                        exp_d   = 4'd1;
                        state_d = StFill;
                    end else begin
                        wr_err_d = 1'b1;
                    end
                end
                StFill: begin
                    if (rk_idx == exp_q) begin
                        we = 1'b1;
                        if (rk_idx == LAST_IDX) begin
                            exp_d   = '0;
                            state_d = StReady;
                        end else begin
                            exp_d = exp_q + 4'd1;
                        end
                    end else if (rk_idx == 4'd0) begin
                        we    = 1'b1;
                        exp_d = 4'd1;
                    end else begin
                        wr_err_d = 1'b1;
                        exp_d    = '0;
                        state_d  = StEmpty;
                    end
                end
                StReady: begin
                    if (rk_idx == 4'd0) begin
                        we      = 1'b1;
                        exp_d   = 4'd1;
                        state_d = StFill;
                    end else begin
                        wr_err_d = 1'b1;
                        exp_d    = '0;
                        state_d  = StEmpty;
                    end
                end
                default: begin
                    exp_d   = '0;
                    state_d = StEmpty;
                end
            endcase
        end
    end

    always_ff @(posedge mclk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= StEmpty;
            exp_q        <= '0;
            rd_valid_q   <= 1'b0;
            rd_err_q     <= 1'b0;
            keys_ready_q <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            rd_valid_q   <= rd_ok;
            rd_err_q     <= rd_req && !rd_ok;
            keys_ready_q <= (state_d == StReady);
            wr_err_q     <= wr_err_d;
        end
    end

    rkey_ram u_ram (
        .mclk    (mclk),
        .arst_n  (arst_n),
        .we      (we),
        .wr_idx  (rk_idx),
        .wr_data (rk_in),
        .re      (rd_ok),
        .rd_idx  (rd_idx),
`ifdef RKEY_PARITY_EN
        .par_err (par_bad),
`endif
        .rd_data (rd_key)
    );

`ifndef RKEY_PARITY_EN
    assign par_bad = 1'b0;
`endif

    assign rd_valid   = rd_valid_q;
    assign rd_err     = rd_err_q | (rd_valid_q & par_bad);
    assign keys_ready = keys_ready_q;
    assign wr_err     = wr_err_q;

endmodule
